// File: rtl/decode_fetch_queue.sv
// rtl/decode_fetch_queue.sv - two-wide fetch-to-decode instruction queue
// Optional macro DECODE_FETCH_QUEUE_NOP_FILTER_EN drops non ALU/load/store ops and canonical NOPs at enqueue.
module decode_fetch_queue #(
  parameter int DEPTH = 8,
  parameter int PCW   = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       fetch_valid_a,
  input  logic                       fetch_valid_b,
  input  logic [31:0]                fetch_inst_a,
  input  logic [31:0]                fetch_inst_b,
  input  logic [PCW-1:0]             fetch_pc_a,
  input  logic [PCW-1:0]             fetch_pc_b,
  output logic                       fetch_ready,
  output logic                       dec_valid_a,
  output logic                       dec_valid_b,
  output logic [31:0]                dec_inst_a,
  output logic [31:0]                dec_inst_b,
  output logic [PCW-1:0]             dec_pc_a,
  output logic [PCW-1:0]             dec_pc_b,
  input  logic [1:0]                 dec_accept,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]    inst_mem [DEPTH];
  logic [PCW-1:0] pc_mem   [DEPTH];
  logic [AW-1:0]  head, tail, head_nxt1, tail_nxt1;
  logic [CW-1:0]  count;
  logic           keep_a, keep_b, wr_en;
  logic [1:0]     enq_n, deq_n, acc_n, avail_n;
  logic [31:0]    wr0_inst;
  logic [PCW-1:0] wr0_pc;

`ifdef DECODE_FETCH_QUEUE_NOP_FILTER_EN
  function automatic logic useful(input logic [31:0] inst);
    logic opc_ok;
    opc_ok = (inst[6:0] == 7'b0110011) || (inst[6:0] == 7'b0010011) ||
             (inst[6:0] == 7'b0000011) || (inst[6:0] == 7'b0100011);
    return opc_ok && (inst != 32'h0000_0013);
  endfunction
  assign keep_a = fetch_valid_a & useful(fetch_inst_a);
  assign keep_b = fetch_valid_a & fetch_valid_b & useful(fetch_inst_b);
`else
  assign keep_a = fetch_valid_a;
  assign keep_b = fetch_valid_a & fetch_valid_b;
`endif

  // Readiness looks only at registered count so a same-cycle dequeue cannot open the door.
  assign fetch_ready = (count <= CW'(DEPTH - 2));
  assign wr_en       = fetch_ready & ~flush & ~reset;
  assign head_nxt1   = head + AW'(1);
  assign tail_nxt1   = tail + AW'(1);

  // Survivors are compacted: a lone surviving slot b lands at tail.
  assign wr0_inst = keep_a ? fetch_inst_a : fetch_inst_b;
  assign wr0_pc   = keep_a ? fetch_pc_a   : fetch_pc_b;

  always_comb begin
    enq_n   = 2'd0;
    if (fetch_ready)
      enq_n = {1'b0, keep_a} + {1'b0, keep_b};
    acc_n   = (dec_accept == 2'd3) ? 2'd2 : dec_accept;
    avail_n = (count >= CW'(2)) ? 2'd2 : count[1:0];
    deq_n   = (acc_n < avail_n) ? acc_n : avail_n;
  end

  always_ff @(posedge clock) begin
    if (wr_en && enq_n != 2'd0) begin
      inst_mem[tail] <= wr0_inst;
      pc_mem[tail]   <= wr0_pc;
    end
    if (wr_en && enq_n == 2'd2) begin
      inst_mem[tail_nxt1] <= fetch_inst_b;
      pc_mem[tail_nxt1]   <= fetch_pc_b;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(deq_n);
      tail  <= tail + AW'(enq_n);
      count <= count + CW'(enq_n) - CW'(deq_n);
    end
  end

  assign dec_valid_a = (count != '0);
  assign dec_valid_b = (count >= CW'(2));
  assign dec_inst_a  = dec_valid_a ? inst_mem[head]      : '0;
  assign dec_pc_a    = dec_valid_a ? pc_mem[head]        : '0;
  assign dec_inst_b  = dec_valid_b ? inst_mem[head_nxt1] : '0;
  assign dec_pc_b    = dec_valid_b ? pc_mem[head_nxt1]   : '0;
  assign occupancy   = count;
endmodule

// File: tb/tb_decode_fetch_queue.sv
// tb/tb_decode_fetch_queue.sv - scoreboard bench for decode_fetch_queue
// Honours DECODE_FETCH_QUEUE_NOP_FILTER_EN in its reference model.
module tb_decode_fetch_queue;
  localparam int DEPTH = 8;
  localparam int PCW   = 32;

  logic clock = 1'b0;
  logic reset, flush, fetch_valid_a, fetch_valid_b, fetch_ready;
  logic [31:0] fetch_inst_a, fetch_inst_b, dec_inst_a, dec_inst_b;
  logic [PCW-1:0] fetch_pc_a, fetch_pc_b, dec_pc_a, dec_pc_b;
  logic dec_valid_a, dec_valid_b;
  logic [1:0] dec_accept;
  logic [$clog2(DEPTH):0] occupancy;

  always #5 clock = ~clock;

  decode_fetch_queue #(.DEPTH(DEPTH), .PCW(PCW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .fetch_valid_a(fetch_valid_a), .fetch_valid_b(fetch_valid_b),
    .fetch_inst_a(fetch_inst_a), .fetch_inst_b(fetch_inst_b),
    .fetch_pc_a(fetch_pc_a), .fetch_pc_b(fetch_pc_b),
    .fetch_ready(fetch_ready),
    .dec_valid_a(dec_valid_a), .dec_valid_b(dec_valid_b),
    .dec_inst_a(dec_inst_a), .dec_inst_b(dec_inst_b),
    .dec_pc_a(dec_pc_a), .dec_pc_b(dec_pc_b),
    .dec_accept(dec_accept), .occupancy(occupancy)
  );

  typedef struct {
    logic [31:0]    inst;
    logic [PCW-1:0] pc;
  } ent_t;

  typedef struct {
    logic           fr, va, vb;
    logic [31:0]    ia, ib;
    logic [PCW-1:0] pa, pb;
    int             occ;
  } exp_t;

  ent_t model_q[$];
  exp_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic bit kept(input logic [31:0] inst);
`ifdef DECODE_FETCH_QUEUE_NOP_FILTER_EN
    if (inst == 32'h0000_0013) return 1'b0;
    return inst[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011};
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expected record per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fetch_ready", 64'(fetch_ready), 64'(e.fr));
        chk("dec_valid_a", 64'(dec_valid_a), 64'(e.va));
        chk("dec_valid_b", 64'(dec_valid_b), 64'(e.vb));
        chk("dec_inst_a",  64'(dec_inst_a),  64'(e.ia));
        chk("dec_inst_b",  64'(dec_inst_b),  64'(e.ib));
        chk("dec_pc_a",    64'(dec_pc_a),    64'(e.pa));
        chk("dec_pc_b",    64'(dec_pc_b),    64'(e.pb));
        chk("occupancy",   64'(occupancy),   64'(e.occ));
      end
    end
  end

  // Drive one cycle of inputs, advance the reference queue, and post the expected outputs.
  task automatic step(input bit rst, input bit fl, input bit fa, input bit fb,
                      input logic [31:0] ia, input logic [31:0] ib,
                      input logic [PCW-1:0] pa, input logic [PCW-1:0] pb,
                      input logic [1:0] acc);
    int sz, want, avail, d;
    bit rdy;
    exp_t e;
    ent_t x;
    reset = rst; flush = fl; fetch_valid_a = fa; fetch_valid_b = fb;
    fetch_inst_a = ia; fetch_inst_b = ib; fetch_pc_a = pa; fetch_pc_b = pb;
    dec_accept = acc;
    sz = model_q.size();
    if (rst || fl) begin
      model_q.delete();
    end else begin
      want  = (acc == 2'd3) ? 2 : int'(acc);
      avail = (sz < 2) ? sz : 2;
      d     = (want < avail) ? want : avail;
      rdy   = (DEPTH - sz) >= 2;
      repeat (d) void'(model_q.pop_front());
      if (rdy && fa) begin
        if (kept(ia)) begin x.inst = ia; x.pc = pa; model_q.push_back(x); end
        if (fb && kept(ib)) begin x.inst = ib; x.pc = pb; model_q.push_back(x); end
      end
    end
    e.occ = model_q.size();
    e.fr  = (DEPTH - e.occ) >= 2;
    e.va  = e.occ >= 1;
    e.vb  = e.occ >= 2;
    e.ia  = e.va ? model_q[0].inst : 32'h0;
    e.pa  = e.va ? model_q[0].pc   : '0;
    e.ib  = e.vb ? model_q[1].inst : 32'h0;
    e.pb  = e.vb ? model_q[1].pc   : '0;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: r[6:0] = 7'b0110011;
      1: r[6:0] = 7'b0000011;
      2: r = 32'h0000_0013;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic [PCW-1:0] pc;
    reset = 1'b1; flush = 1'b0; fetch_valid_a = 1'b0; fetch_valid_b = 1'b0;
    fetch_inst_a = '0; fetch_inst_b = '0; fetch_pc_a = '0; fetch_pc_b = '0;
    dec_accept = 2'd0;
    @(negedge clock);
    step(1, 0, 1, 1, 32'h00500093, 32'h00A00113, 32'h100, 32'h104, 2'd2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
    // First pair, then a third entry, then single dequeue.
    step(0, 0, 1, 1, 32'h00500093, 32'h00A00113, 32'h100, 32'h104, 2'd0);
    step(0, 0, 1, 0, 32'h00308193, 32'h0, 32'h108, 32'h0, 2'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'd1);
    // Fill to full, offer another pair, then trim to 5 and flush with a pair.
    step(1, 0, 0, 0, 0, 0, 0, 0, 2'd0);
    for (int i = 0; i < 5; i++)
      step(0, 0, 1, 1, 32'h00000033 | (i << 7), 32'h00000003 | (i << 7),
           32'h200 + 8 * i, 32'h204 + 8 * i, 2'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'd3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'd1);
    step(0, 1, 1, 1, 32'h00000033, 32'h00000023, 32'h300, 32'h304, 2'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'd2);
    // Walk head/tail to index 7, then write a wrapping pair and pull it out.
    for (int i = 0; i < 7; i++)
      step(0, 0, 1, 0, 32'h00000013 | (32'(i + 1) << 20), 32'h0, 32'h400 + 4 * i, 32'h0, 2'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'd1);
    step(0, 0, 1, 1, 32'hAAAA_A033, 32'h5555_5003, 32'h500, 32'h504, 2'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'd2);
    // Canonical NOP in slot a with a live slot b.
    step(0, 0, 1, 1, 32'h00000013, 32'h002081B3, 32'h600, 32'h604, 2'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'd2);
    // Randomised traffic with phases of slow and fast drain.
    for (int i = 0; i < 1500; i++) begin
      logic [1:0] acc;
      pc = $urandom;
      pc[1:0] = 2'b00;
      acc = (i % 300 < 120) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
      step($urandom_range(0, 149) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           rand_inst(), rand_inst(), pc, pc + 4, acc);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
    @(posedge clock);
    #2;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/decode_fetch_queue.md
Name: decode_fetch_queue

Overview:
- Two-wide instruction buffer between fetch and the dual-slot (a/b) decoder of the OoO core.
- Accepts up to two instructions per cycle from fetch and presents the two oldest to decode slots a and b in program order.
- Retires 0, 1 or 2 entries per cycle according to the downstream accept count.
- Supports a full flush on branch mispredict or exception.

Parameters:
- DEPTH, 8, number of queue entries; power of two, minimum 4.
- PCW, 32, PC width in bits.

Ports:
- clock  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous queue clear; higher priority than any enqueue or dequeue.
- fetch_valid_a  in  1  fetch slot a holds an instruction (older of the pair).
- fetch_valid_b  in  1  fetch slot b holds an instruction (younger); ignored unless fetch_valid_a is high.
- fetch_inst_a  in  32  instruction word for slot a.
- fetch_inst_b  in  32  instruction word for slot b.
- fetch_pc_a  in  PCW  PC of slot a.
- fetch_pc_b  in  PCW  PC of slot b.
- fetch_ready  out  1  queue can take a full pair this cycle.
- dec_valid_a  out  1  head entry is valid.
- dec_valid_b  out  1  head+1 entry is valid.
- dec_inst_a  out  32  head instruction; 0 when dec_valid_a is low.
- dec_inst_b  out  32  head+1 instruction; 0 when dec_valid_b is low.
- dec_pc_a  out  PCW  head PC; 0 when dec_valid_a is low.
- dec_pc_b  out  PCW  head+1 PC; 0 when dec_valid_b is low.
- dec_accept  in  2  entries consumed by decode/rename this cycle: 0, 1 or 2.
- occupancy  out  $clog2(DEPTH)+1  current entry count.

Behaviour:
- State: entry array (inst, pc), head pointer, tail pointer, count. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Reset: head=0, tail=0, count=0. Outputs while reset is high and on the following cycle: fetch_ready=1, dec_valid_a/b=0, dec_inst_a/b=0, dec_pc_a/b=0, occupancy=0. Entry array is not cleared.
- fetch_ready = (DEPTH - count) >= 2. It depends only on registered count; a same-cycle dequeue never raises it combinationally.
- Enqueue happens only when fetch_ready is high:
  - fetch_valid_a alone writes 1 entry at tail.
  - fetch_valid_a with fetch_valid_b writes slot a at tail and slot b at tail+1 (wrapped).
  - tail advances by the number written.
  - fetch_valid_b without fetch_valid_a writes nothing.
- Presentation is combinational from registered state:
  - dec_valid_a = count >= 1; dec_valid_b = count >= 2.
  - dec_inst_a/dec_pc_a come from entry[head]; dec_inst_b/dec_pc_b come from entry[head+1], wrapped.
- Dequeue:
  - effective accept = min(dec_accept, number of valid outputs); dec_accept=3 is treated as 2.
  - head advances by the effective accept.
- Simultaneous enqueue and dequeue in one cycle: count_next = count + enq - deq.
- Latency: an instruction written at edge N is visible on dec_* after edge N (zero-bubble), provided it reaches the head.
- Flush:
  - Next state is head=tail=count=0, same as reset. Any enqueue and dequeue in that cycle are discarded.
  - The cycle after flush, outputs equal their reset values.
  - Flush asserted together with reset gives the same result as reset.
- Full: count=DEPTH-1 or DEPTH gives fetch_ready=0; a fetch pair in that cycle is dropped, and fetch must hold it.
- Empty: count=0 with dec_accept nonzero gives no dequeue; count stays 0.
- Wrap-around: a pair written at tail=DEPTH-1 places slot b at index 0. A head read at index DEPTH-1 takes slot b data from index 0.

Optional Feature:
- Macro: DECODE_FETCH_QUEUE_NOP_FILTER_EN.
- Defined:
  - At enqueue, drop any fetch instruction whose opcode [6:0] is not 0110011, 0010011, 0000011 or 0100011.
  - Also drop the canonical NOP 32'h00000013.
  - Surviving instructions are compacted in order: if only slot b survives, it is written at tail.
  - tail and count advance by the number of survivors. fetch_ready rule is unchanged.
- Undefined: every fetch instruction offered while fetch_ready is high is enqueued unchanged.

Test Plan:
- Reset, then fetch pair a=32'h00500093 pc=0x100, b=32'h00A00113 pc=0x104, dec_accept=0 -> next cycle dec_valid_a=dec_valid_b=1, dec_inst_a=32'h00500093, dec_pc_b=0x104, occupancy=2.
- Queue holds 3 entries, dec_accept=1, no fetch -> next cycle head advances by 1; old entry 2 appears on slot a; occupancy=2.
- DEPTH=8: fill with 4 fetch pairs and dec_accept=0 -> occupancy=8, fetch_ready=0; a further pair is not written, and entries at head are unchanged.
- Advance head/tail to 7, then enqueue a pair -> entries land at indices 7 and 0; a dequeue of 2 returns them in order on slots a/b.
- Occupancy 5, fetch pair and flush in the same cycle -> next cycle occupancy=0, dec_valid_a/b=0, dec_inst_a=0, fetch_ready=1.
- With the NOP filter macro defined, fetch a=32'h00000013 and b=32'h002081B3 -> only b is enqueued, at tail; occupancy +1. Without the macro -> occupancy +2.
